// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction fetch with PC register, memory request and IF/ID register.
// Wrong-path words are squashed; a word returning under decode stall is parked in a skid buffer.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc_f,
   input  logic [31:0] pc_plus4_f,
   input  logic        stall_d,
   input  logic        branch_d,
   input  logic [31:0] branch_target,
   input  logic        jump_d,
   input  logic [31:0] jump_target,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ready,
   input  logic [31:0] inst_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc_plus4_d,
   output logic        valid_d
);
   typedef enum logic [1:0] {IDLE, FETCH, KILL, BUF} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d, redir_q, redir_d, buf_q, buf_d;
   logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        redirect, bubble, load;
   logic [31:0] target, word;
   assign redirect   = !stall_d && (jump_d || branch_d);
   assign target     = jump_d ? jump_target : branch_target;
   assign inst_req   = (state_q == FETCH) || (state_q == KILL);
   assign inst_addr  = pc_f_q;
   assign pc_f       = pc_f_q;
   assign instr_d    = ifid_instr_q;
   assign pc_d       = ifid_pc_q;
   assign pc_plus4_d = ifid_pc4_q;
   assign valid_d    = ifid_valid_q;
   always_comb begin
      state_d = state_q;
      pc_f_d  = pc_f_q;
      redir_d = redir_q;
      buf_d   = buf_q;
      bubble  = 1'b0;
      load    = 1'b0;
      word    = inst_rdata;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH:
            if (redirect) begin
               bubble = 1'b1;
               if (inst_ready) pc_f_d = target;
               else begin
                  redir_d = target;
                  state_d = KILL;
               end
            end else if (inst_ready && !stall_d) begin
               load   = 1'b1;
               pc_f_d = pc_plus4_f;
            end else if (inst_ready) begin
               buf_d   = inst_rdata;
               state_d = BUF;
            end else bubble = !stall_d;
         KILL: begin
            // the in-flight word must still complete before the new PC may be requested
            bubble = !stall_d;
            if (redirect) redir_d = target;
            if (inst_ready) begin
               pc_f_d  = redirect ? target : redir_q;
               state_d = FETCH;
            end
         end
         BUF:
            if (redirect) begin
               bubble  = 1'b1;
               pc_f_d  = target;
               state_d = FETCH;
            end else if (!stall_d) begin
               load    = 1'b1;
               word    = buf_q;
               pc_f_d  = pc_plus4_f;
               state_d = FETCH;
            end
         default: state_d = IDLE;
      endcase
      ifid_valid_d = load ? 1'b1 : bubble ? 1'b0 : ifid_valid_q;
      ifid_instr_d = load ? word : bubble ? 32'h0 : ifid_instr_q;
      ifid_pc_d    = load ? pc_f_q : ifid_pc_q;
      ifid_pc4_d   = load ? pc_plus4_f : ifid_pc4_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_f_q       <= RESET_PC;
         redir_q      <= 32'h0;
         buf_q        <= 32'h0;
         ifid_instr_q <= 32'h0;
         ifid_pc_q    <= 32'h0;
         ifid_pc4_q   <= 32'h0;
         ifid_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         redir_q      <= redir_d;
         buf_q        <= buf_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: cycle-accurate scoreboard bench for fetch_stage with a word=address memory.
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_f, pc_plus4_f, branch_target, jump_target, inst_addr, inst_rdata;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        stall_d, branch_d, jump_d, inst_req, inst_ready, valid_d;
   int          checks = 0;
   int          errors = 0;
   typedef struct {logic v; logic [31:0] pc;} exp_t;
   exp_t        sb[$];
   always #5 clk = ~clk;
   assign pc_plus4_f = pc_f + 32'd4;
   // a bogus word whenever no request is outstanding exposes any use of the live bus in BUF
   assign inst_rdata = inst_req ? inst_addr : 32'hDEAD_BEEF;
   fetch_stage dut (
      .clk(clk), .rst(rst), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .stall_d(stall_d),
      .branch_d(branch_d), .branch_target(branch_target), .jump_d(jump_d),
      .jump_target(jump_target), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_ready(inst_ready), .inst_rdata(inst_rdata), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(input logic st, input logic br, input logic jp, input logic [31:0] tgt,
                      input logic rdy, input logic ereq, input logic [31:0] eaddr,
                      input logic ev, input logic [31:0] epc);
      exp_t e;
      stall_d       = st;
      branch_d      = br;
      jump_d        = jp;
      jump_target   = tgt;
      branch_target = jp ? 32'h0000_0600 : tgt;
      inst_ready    = rdy;
      #1;
      chk("inst_req", {31'b0, inst_req}, {31'b0, ereq});
      chk("inst_addr", inst_addr, eaddr);
      sb.push_back('{ev, epc});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("valid_d", {31'b0, valid_d}, {31'b0, e.v});
      if (e.v) begin
         chk("pc_d", pc_d, e.pc);
         chk("pc_plus4_d", pc_plus4_d, e.pc + 32'd4);
         chk("instr_d", instr_d, e.pc);
      end else chk("instr_d_bubble", instr_d, 32'h0);
      @(negedge clk);
   endtask
   task automatic fetch(input logic [31:0] a);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, a, 1'b1, a);
   endtask
   task automatic stream(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) fetch(a + 32'(4 * i));
   endtask
   task automatic do_reset();
      stall_d    = 1'b0;
      branch_d   = 1'b0;
      jump_d     = 1'b0;
      inst_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_req", {31'b0, inst_req}, 32'h0);
      chk("rst_pc_f", pc_f, 32'h0);
      chk("rst_valid", {31'b0, valid_d}, 32'h0);
      chk("rst_instr", instr_d, 32'h0);
      chk("rst_pc_d", pc_d, 32'h0);
      chk("rst_pc4_d", pc_plus4_d, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask
   initial begin
      do_reset();
      stream(32'h0, 4);
      do_reset();
      stream(32'h0, 2);
      cyc(1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h8, 1'b0, 32'h0);
      stream(32'h100, 2);
      do_reset();
      stream(32'h0, 3);
      cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 1'b0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, 32'h0);
      stream(32'h40, 2);
      do_reset();
      stream(32'h0, 4);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'hC);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'hC);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10);
      stream(32'h14, 2);
      do_reset();
      fetch(32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 32'h4, 1'b1, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0);
      stream(32'h200, 2);
      cyc(1'b0, 1'b1, 1'b1, 32'h500, 1'b1, 1'b1, 32'h208, 1'b0, 32'h0);
      fetch(32'h500);
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h504, 1'b0, 32'h0);
      fetch(32'hFFFF_FFFC);
      fetch(32'h0);
      do_reset();
      fetch(32'h0);
      cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
      do_reset();
      stream(32'h0, 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS pipeline. It owns the PC register, drives the instruction-memory request, and loads the IF/ID pipeline register. It feeds `pc_f` to the external PC+4 `adder` and consumes that adder's sum as the sequential next PC. It accepts a redirect (branch or jump target) from decode; there is no delay slot, so wrong-path fetches are squashed.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `pc_f` out 32: current fetch PC; drives adder input `a` (with `b` = 4).
- `pc_plus4_f` in 32: adder sum `pc_f + 4`; used as the sequential next PC.
- `stall_d` in 1: decode stall; hold IF/ID and ignore redirects this cycle.
- `branch_d` in 1, `branch_target` in 32: taken-branch redirect.
- `jump_d` in 1, `jump_target` in 32: jump redirect; has priority over branch.
- `inst_req` out 1, `inst_addr` out 32: memory request; `inst_addr` = `pc_f`.
- `inst_ready` in 1, `inst_rdata` in 32: memory response; valid in the same cycle as `inst_ready` (may be the request cycle).
- `instr_d`, `pc_d`, `pc_plus4_d` out 32 each, and `valid_d` out 1: IF/ID register contents.

## Operation
- Redirect = `!stall_d && (jump_d || branch_d)`. Target = `jump_target` if `jump_d`, else `branch_target`. Redirect while `stall_d` is ignored.
- Bubble = IF/ID loads `valid_d`=0 and `instr_d`=0; `pc_d` and `pc_plus4_d` are don't-care but hold their value.
- Request protocol: while `inst_req`=1, `inst_addr` stays stable until `inst_ready`. `inst_req` is combinational from state.
- States:
  - IDLE: reset state. `inst_req`=0. Next state is FETCH unconditionally. IF/ID holds reset values.
  - FETCH: `inst_req`=1.
    - Redirect and `inst_ready`: drop word, `pc_f`<=target, bubble, stay in FETCH.
    - Redirect without `inst_ready`: `redir_pc`<=target, bubble, go to KILL.
    - `inst_ready` and `!stall_d`: IF/ID<={`inst_rdata`, `pc_f`, `pc_plus4_f`}, `valid_d`<=1, `pc_f`<=`pc_plus4_f`.
    - `inst_ready` and `stall_d`: `buf`<=`inst_rdata`, go to BUF, IF/ID holds.
    - No `inst_ready`: bubble if `!stall_d`, else hold.
  - KILL: `inst_req`=1 at the old `pc_f`. A new redirect overwrites `redir_pc`. IF/ID takes a bubble if `!stall_d`, else holds. On `inst_ready`: drop word, `pc_f`<=`redir_pc` (or the new target if a redirect occurs in the same cycle), go to FETCH.
  - BUF: `inst_req`=0. `pc_f` still equals the buffered word's PC.
    - `stall_d`: hold everything.
    - Redirect: discard `buf`, `pc_f`<=target, bubble, go to FETCH.
    - Otherwise: IF/ID<={`buf`, `pc_f`, `pc_plus4_f`}, `valid_d`<=1, `pc_f`<=`pc_plus4_f`, go to FETCH.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag. PC bits [1:0] are passed through unmodified; alignment is not checked.

## Timing
- Reset (async, immediate):
  - `pc_f`=RESET_PC, state=IDLE, `inst_req`=0.
  - `valid_d`=0; `instr_d`, `pc_d` and `pc_plus4_d` are 0.
  - `redir_pc`=0, `buf`=0.
- First request is in the cycle after the first rising edge with `rst` low.
- Zero-wait memory (`inst_ready` held at 1): one instruction per cycle. The word requested in cycle N appears on `instr_d` after edge N.
- Redirect-to-target-request latency is 1 cycle when the in-flight fetch completes in the redirect cycle. Otherwise it is 1 cycle after the killed fetch's `inst_ready`.
- Reset asserted in KILL or BUF abandons the pending fetch and buffer. Memory must tolerate `inst_req` dropping before `inst_ready`.
- Simultaneous `jump_d` and `branch_d`: jump target is used.

## Test plan
- Reset then stream:
  - Stimulus: RESET_PC=0, `inst_ready`=1, memory returns word = address.
  - Required: `pc_d` sequence 0,4,8,C with `valid_d`=1 from the second cycle after reset release; `instr_d`=`pc_d`; `pc_plus4_d`=`pc_d`+4.
- Branch, zero-wait:
  - Stimulus: `branch_d`=1 with target 0x100 while fetching 0x8.
  - Required: one bubble (`valid_d`=0); next `pc_d`=0x100; 0x8 is never delivered.
- Redirect during wait:
  - Stimulus: `inst_ready`=0 for 3 cycles at 0xC; `jump_d` with target 0x40 in cycle 1.
  - Required: `inst_addr` stays 0xC until ready. The word at 0xC is dropped. Next request is to 0x40, and `pc_d`=0x40 is the next valid output.
- Stall skid:
  - Stimulus: `stall_d`=1 while the word at 0x10 returns; hold for 2 cycles, then release.
  - Required: `inst_req`=0 during the hold and IF/ID unchanged. After release, `pc_d`=0x10 with correct `instr_d`, and the next request is to 0x14.
- Redirect ignored under stall, then buffered discard:
  - Stimulus: state BUF, `branch_d`=1 with `stall_d`=1; then `branch_d`=1 with `stall_d`=0 and target 0x200.
  - Required: the first branch has no effect. The second discards the buffer, inserts a bubble, and the next request is to 0x200.
- Async reset mid-KILL:
  - Stimulus: assert `rst` between edges.
  - Required: `pc_f`=RESET_PC, `valid_d`=0 and `inst_req`=0 immediately; normal fetch from RESET_PC after release.
